// File: rtl/i2c_master_burst.sv
// I2C master: one START / address / N data bytes / STOP burst per rising edge of iSTART.
// Define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL (bit timing then waits on synchronised SCL).
module i2c_master_burst #(
    parameter int CLK_Freq  = 50_000_000,
    parameter int I2C_Freq  = 400_000,
    parameter int MAX_BYTES = 16,
    localparam int LW = $clog2(MAX_BYTES + 1)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iSTART,
    input  logic          iREAD,
    input  logic [6:0]    I2C_ADDR,
    input  logic [LW-1:0] I2C_LEN,
    input  logic [7:0]    I2C_WDATA,
    output logic          oWREQ,
    output logic [7:0]    I2C_RDATA,
    output logic          oRVALID,
    output logic          oBUSY,
    output logic          oEND,
    output logic          oACK,
    inout  wire           I2C_SCL,
    inout  wire           I2C_SDA
);

    localparam int AW = $clog2(CLK_Freq + 4 * I2C_Freq + 1);
    localparam logic [AW-1:0] INC     = AW'(4 * I2C_Freq);
    localparam logic [AW-1:0] WRAP    = AW'(CLK_Freq);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);

    typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WBYTE, WACK, RBYTE, MACK, STOP} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic          tick;
    logic          hold;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [LW-1:0] cnt;
    logic [7:0]    shreg;
    logic          rd_q;
    logic          nak_q;
    logic          start_q;
    logic          scl_oe;
    logic          sda_oe;

    // Open-drain pads: *_oe=1 pulls the line low, otherwise it floats high.
    assign I2C_SCL = scl_oe ? 1'b0 : 1'bz;
    assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

    // Quarter-SCL-period tick from a phase accumulator.
    assign acc_sum = acc + INC;
    assign tick    = (acc_sum >= WRAP);

`ifdef I2C_CLOCK_STRETCH_EN
    logic scl_s1;
    logic scl_s2;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= I2C_SCL;
            scl_s2 <= scl_s1;
        end
    end

    // Phase 2 follows our SCL release; stall until the line is really high.
    assign hold = (phase == 2'd2) && !scl_s2;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= IDLE;
            acc       <= '0;
            phase     <= 2'd0;
            bit_cnt   <= 3'd0;
            cnt       <= '0;
            shreg     <= 8'h00;
            rd_q      <= 1'b0;
            nak_q     <= 1'b0;
            start_q   <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            oEND      <= 1'b1;
            oBUSY     <= 1'b0;
            oACK      <= 1'b0;
            oWREQ     <= 1'b0;
            oRVALID   <= 1'b0;
            I2C_RDATA <= 8'h00;
        end else begin
            start_q <= iSTART;
            oWREQ   <= 1'b0;
            oRVALID <= 1'b0;
            if (oWREQ) shreg <= I2C_WDATA;

            if (state == IDLE) begin
                acc     <= '0;
                phase   <= 2'd0;
                bit_cnt <= 3'd0;
                if (iSTART && !start_q) begin
                    rd_q  <= iREAD;
                    shreg <= {I2C_ADDR, iREAD};
                    cnt   <= (I2C_LEN > MAX_LEN) ? MAX_LEN : I2C_LEN;
                    oACK  <= 1'b0;
                    oEND  <= 1'b0;
                    oBUSY <= 1'b1;
                    state <= START;
                end
            end else if (!hold) begin
                acc <= tick ? acc_sum - WRAP : acc_sum;
                if (tick) begin
                    phase <= phase + 2'd1;
                    case (state)
                        START: begin
                            if (phase == 2'd0) sda_oe <= 1'b1;
                            if (phase == 2'd3) begin
                                scl_oe <= 1'b1;
                                state  <= ADDR;
                            end
                        end
                        ADDR, WBYTE: begin
                            case (phase)
                                2'd0: sda_oe <= ~shreg[7];
                                2'd1: scl_oe <= 1'b0;
                                2'd3: begin
                                    scl_oe  <= 1'b1;
                                    shreg   <= {shreg[6:0], 1'b0};
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state <= (state == ADDR) ? AACK : WACK;
                                end
                                default: ;
                            endcase
                        end
                        AACK, WACK: begin
                            case (phase)
                                2'd0: sda_oe <= 1'b0;
                                2'd1: scl_oe <= 1'b0;
                                2'd2: nak_q  <= I2C_SDA;
                                2'd3: begin
                                    scl_oe <= 1'b1;
                                    if (nak_q) begin
                                        oACK  <= 1'b1;
                                        state <= STOP;
                                    end else if (state == AACK) begin
                                        if (cnt == '0) state <= STOP;
                                        else if (rd_q) state <= RBYTE;
                                        else begin
                                            oWREQ <= 1'b1;
                                            state <= WBYTE;
                                        end
                                    end else begin
                                        cnt <= cnt - LW'(1);
                                        if (cnt == LW'(1)) state <= STOP;
                                        else begin
                                            oWREQ <= 1'b1;
                                            state <= WBYTE;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                        RBYTE: begin
                            case (phase)
                                2'd0: sda_oe <= 1'b0;
                                2'd1: scl_oe <= 1'b0;
                                2'd2: begin
                                    shreg <= {shreg[6:0], I2C_SDA};
                                    if (bit_cnt == 3'd7) begin
                                        I2C_RDATA <= {shreg[6:0], I2C_SDA};
                                        oRVALID   <= 1'b1;
                                    end
                                end
                                2'd3: begin
                                    scl_oe  <= 1'b1;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state <= MACK;
                                end
                                default: ;
                            endcase
                        end
                        MACK: begin
                            // ACK every byte but the last, which is NAKed to end the read.
                            case (phase)
                                2'd0: sda_oe <= (cnt != LW'(1));
                                2'd1: scl_oe <= 1'b0;
                                2'd3: begin
                                    scl_oe <= 1'b1;
                                    cnt    <= cnt - LW'(1);
                                    state  <= (cnt == LW'(1)) ? STOP : RBYTE;
                                end
                                default: ;
                            endcase
                        end
                        STOP: begin
                            case (phase)
                                2'd0: sda_oe <= 1'b1;
                                2'd1: scl_oe <= 1'b0;
                                2'd2: sda_oe <= 1'b0;
                                2'd3: begin
                                    oEND  <= 1'b1;
                                    oBUSY <= 1'b0;
                                    state <= IDLE;
                                end
                                default: ;
                            endcase
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/i2c_master_burst.md
I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

Interface
REQ-001 SHALL have parameter CLK_Freq, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_Freq, default 400_000, SCL frequency in Hz.
REQ-003 SHALL have parameter MAX_BYTES, default 16, maximum data bytes per transaction; LW = $clog2(MAX_BYTES+1).
REQ-004 SHALL have port iCLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port iSTART  in  1  rising edge requests a transaction.
REQ-007 SHALL have port iREAD  in  1  1 = read transaction, 0 = write; sampled at start.
REQ-008 SHALL have port I2C_ADDR  in  7  target address; sampled at start.
REQ-009 SHALL have port I2C_LEN  in  LW  data byte count, 0..MAX_BYTES; sampled at start.
REQ-010 SHALL have port I2C_WDATA  in  8  next write byte; valid when oWREQ is asserted.
REQ-011 SHALL have port oWREQ  out  1  one-cycle pulse: I2C_WDATA captured.
REQ-012 SHALL have port I2C_RDATA  out  8  last received byte, MSB first on the bus.
REQ-013 SHALL have port oRVALID  out  1  one-cycle pulse: I2C_RDATA updated.
REQ-014 SHALL have port oBUSY  out  1  transaction in progress.
REQ-015 SHALL have port oEND  out  1  high when idle or finished.
REQ-016 SHALL have port oACK  out  1  sticky error flag: any NAK seen in this transaction.
REQ-017 SHALL have port I2C_SCL  inout  1  open-drain: drives 0 or Z.
REQ-018 SHALL have port I2C_SDA  inout  1  open-drain: drives 0 or Z.

Function
REQ-019 Tick generator SHALL use a phase accumulator: add 4*I2C_Freq each cycle, wrap at CLK_Freq. This gives one tick per quarter SCL period. Each bit SHALL take 4 ticks: SDA change, SCL release, sample, SCL low.
REQ-020 FSM states SHALL be IDLE, START, ADDR, AACK, WBYTE, WACK, RBYTE, MACK, STOP.
REQ-021 IDLE SHALL advance to START on a rising edge of iSTART. It SHALL latch iREAD, I2C_ADDR and I2C_LEN, clear oACK, drop oEND and raise oBUSY in the same cycle.
REQ-022 iSTART edges SHALL be ignored while oBUSY=1.
REQ-023 START SHALL pull SDA low while SCL is high, then pull SCL low.
REQ-024 ADDR SHALL shift out {I2C_ADDR, iREAD} MSB first. AACK SHALL sample SDA on the third tick; SDA=1 means NAK.
REQ-025 A NAK in AACK or WACK SHALL set oACK=1 and jump to STOP. No further data SHALL move.
REQ-026 With I2C_LEN=0 (probe), the FSM SHALL go from AACK to STOP.
REQ-027 Write: oWREQ SHALL pulse one cycle before each WBYTE begins, and I2C_WDATA SHALL be captured in that same cycle. Exactly I2C_LEN pulses SHALL occur when every byte is ACKed.
REQ-028 Read: RBYTE SHALL release SDA and sample 8 bits. I2C_RDATA and oRVALID SHALL update in the cycle after bit 0 is sampled.
REQ-029 MACK SHALL drive ACK (0) for every byte except the last, and NAK (1) on the last.
REQ-030 STOP SHALL drive SDA low, release SCL, then release SDA. The FSM SHALL then return to IDLE with oEND=1 and oBUSY=0.
REQ-031 I2C_LEN values above MAX_BYTES SHALL saturate to MAX_BYTES.
REQ-032 The byte counter SHALL decrement once per data byte, and the transaction SHALL end when it reaches 0; there is no wrap.

Reset
REQ-033 While iRST_N=0 at a clock edge, the block SHALL force: FSM=IDLE, accumulator=0, SCL=Z, SDA=Z, oEND=1, oBUSY=0, oACK=0, oWREQ=0, oRVALID=0, I2C_RDATA=8'h00.
REQ-034 A reset in mid-transaction SHALL release both lines in the same cycle. No STOP SHALL be generated.

Configuration
REQ-035 Macro I2C_CLOCK_STRETCH_EN SHALL control clock stretching.
REQ-036 With the macro defined: SCL SHALL be sampled through a 2-flop synchroniser. After each SCL release, the FSM and accumulator SHALL hold until synchronised SCL=1, so a slave can stretch the clock indefinitely.
REQ-037 With the macro undefined: SCL SHALL be output-only and timing SHALL be purely tick-based.

Verification
REQ-038 Write, addr 7'h1A, I2C_LEN=2, data 8'hA5 then 8'h3C, all bytes ACKed -> bus carries 0x34, A5, 3C; oWREQ pulses twice; oACK=0; oEND rises after STOP.
REQ-039 Read, addr 7'h50, I2C_LEN=3, slave sends 11, 22, 33 -> oRVALID pulses 3 times with 8'h11, 8'h22, 8'h33; master sends ACK, ACK, NAK; oACK=0.
REQ-040 Address NAK, addr 7'h7F, write, I2C_LEN=4 -> oACK=1; zero oWREQ pulses; STOP issued; oEND=1.
REQ-041 iRST_N=0 during bit 4 of the second byte -> next cycle SCL=Z, SDA=Z, oEND=1; a fresh iSTART then completes normally.
REQ-042 I2C_CLOCK_STRETCH_EN defined, slave holds SCL low for 200 cycles after the ACK bit -> no edge is lost and the data byte is still correct.
REQ-043 iSTART pulsed while oBUSY=1, and I2C_LEN=0 probe of 7'h1A -> the extra pulse is ignored; the probe produces address plus STOP only, with oACK=0.
